// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  // Fetch FSM state encoding (2 bits).
  typedef enum logic [1:0] {
    FetchIdle  = 2'd0,
    FetchRun   = 2'd1,
    FetchDrain = 2'd2
  } fetch_state_e;

  // Entries in the fetch buffer; the issue rule relies on this being 2.
  localparam int unsigned FetchBufDepth = 2;

  // Room check used by the issue rule: words already owned by the stage
  // (buffered + in flight) minus the one leaving this cycle must be below depth.
  function automatic logic buf_has_room(input logic [1:0] count, input logic inflight,
                                        input logic pop);
    logic [2:0] occ;
    occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    return occ < 3'(FetchBufDepth);
  endfunction

endpackage

// File: rtl/fetch_unit_buf.sv
// Fetch buffer: 2-entry {pc, instr} FIFO with push, pop, synchronous clear and
// occupancy count. Clear wins over a same-cycle push.
module fetch_unit_buf
  import fetch_unit_pkg::*;
#(
  parameter int unsigned IW  = 12,
  parameter int unsigned IMW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [IMW-1:0] push_pc,
  input  logic [IW-1:0]  push_instr,
  input  logic           pop,
  input  logic           clear,
  output logic [IMW-1:0] head_pc,
  output logic [IW-1:0]  head_instr,
  output logic [1:0]     count
);

  logic [IW-1:0]  instr_q [FetchBufDepth];
  logic [IW-1:0]  instr_d [FetchBufDepth];
  logic [IMW-1:0] pc_q    [FetchBufDepth];
  logic [IMW-1:0] pc_d    [FetchBufDepth];
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic [1:0]     count_q, count_d;

  // Next-state: write at wr_ptr, advance pointers, track occupancy.
  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = push_instr;
        pc_d[wr_ptr_q]    = push_pc;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q  <= '{default: '0};
      pc_q     <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_instr = instr_q[rd_ptr_q];
  assign head_pc    = pc_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives a sync-read instruction memory, buffers the
// returned words and hands {instr, pc} to decode over valid/ready.
// Optional feature macro: FETCH_STALL_CNT_EN enables the back-pressure counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned IW  = 12,
  parameter int unsigned IMW = 4,
  parameter int unsigned RFW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fetch_en,
  output logic           imem_rd_en,
  output logic [IMW-1:0] imem_addr,
  input  logic [IW-1:0]  imem_rdata,
  output logic           instr_valid,
  input  logic           instr_ready,
  output logic [IW-1:0]  instr_out,
  output logic [IMW-1:0] pc_out,
  input  logic           redirect_valid,
  input  logic [IMW-1:0] redirect_pc,
  output logic [15:0]    stall_cnt
);

  // Register-address width only matters to decode.
  logic [RFW-1:0] unused_rfw;
  assign unused_rfw = '0;

  fetch_state_e   state_q, state_d;
  logic [IMW-1:0] pc_q, pc_d;
  // A read issued last cycle; its data is on imem_rdata this cycle.
  logic           inflight_q, inflight_d;
  // Address of that read, tagged onto the returning word.
  logic [IMW-1:0] inflight_pc_q, inflight_pc_d;

  logic       issue;
  logic       push;
  logic       pop;
  logic [1:0] buf_count;

  assign instr_valid = (buf_count != 2'd0);
  assign pop         = instr_valid && instr_ready;
  // A redirect makes any returning word stale: it is dropped instead of pushed.
  // The queue is flushed on every redirect, whatever the FSM state.
  assign push        = inflight_q && !redirect_valid;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FetchIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FetchIdle:  if (fetch_en) state_d = FetchRun;
      FetchRun:   if (!fetch_en) state_d = FetchDrain;
      FetchDrain: begin
        if (fetch_en) begin
          state_d = FetchRun;
        end else if (!inflight_q) begin
          state_d = FetchIdle;
        end
      end
      default:    state_d = FetchIdle;
    endcase
  end

  // FSM outputs: issue a read only in RUN, never on a redirect, and only if
  // the word will have a buffer slot when it returns.
  always_comb begin
    issue = (state_q == FetchRun) && !redirect_valid &&
            buf_has_room(buf_count, inflight_q, pop);
  end

  assign imem_rd_en = issue;
  assign imem_addr  = pc_q;

  // PC and in-flight tracking next-state.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (issue) begin
      inflight_pc_d = pc_q;
    end
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d = pc_q + IMW'(1);
    end
  end

  // PC and in-flight registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_unit_buf #(
    .IW  (IW),
    .IMW (IMW)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (inflight_pc_q),
    .push_instr (imem_rdata),
    .pop        (pop),
    .clear      (redirect_valid),
    .head_pc    (pc_out),
    .head_instr (instr_out),
    .count      (buf_count)
  );

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where decode holds off a valid word; saturate at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (instr_valid && !instr_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule
